// File: rtl/sym_feeder.sv
// Byte FIFO feeding a 2-bit symbol stream: unpacks bytes MSB pair first and inserts
// sync symbols (3) at byte boundaries on request.
module sym_feeder #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [1:0]  IDLE_SYM = 2'd0
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_wr_en,
    input  logic [7:0] i_wr_data,
    output logic       o_full,
    output logic       o_empty,
    output logic       o_overflow,
    input  logic       i_sync_req,
    output logic [1:0] o_sym_out,
    output logic       o_sym_valid
);

    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StSync
    } state_e;

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          r_overflow;
    logic          r_pend;
    state_e        r_state;
    logic [1:0]    r_idx;
    logic [7:0]    r_shreg;
    logic [1:0]    r_sym_out;
    logic          r_sym_valid;

    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic          w_pend_next;
    logic [7:0]    w_head;

    assign w_full  = (r_count == (AW + 1)'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_push  = i_wr_en && !w_full;
    assign w_head  = r_mem[r_rd_ptr];

    // In SYNC the pending flag is consumed; only a request in that very cycle re-arms it.
    assign w_pend_next = (r_state == StSync) ? i_sync_req : (r_pend || i_sync_req);

    always_comb begin
        w_pop = 1'b0;
        case (r_state)
            StIdle:  w_pop = !r_pend && !w_empty;
            StShift: w_pop = (r_idx == 2'd3) && !r_pend && !w_empty;
            StSync:  w_pop = !i_sync_req && !w_empty;
            default: w_pop = 1'b0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (i_wr_en && w_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Outputs are computed for the state being entered, so they are registered alongside it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= StIdle;
            r_idx       <= 2'd0;
            r_shreg     <= 8'd0;
            r_pend      <= 1'b0;
            r_sym_out   <= IDLE_SYM;
            r_sym_valid <= 1'b0;
        end else begin
            r_pend <= w_pend_next;
            if (w_pop) begin
                r_state     <= StShift;
                r_idx       <= 2'd0;
                r_shreg     <= w_head;
                r_sym_out   <= w_head[7:6];
                r_sym_valid <= 1'b1;
            end else begin
                case (r_state)
                    StIdle: begin
                        if (r_pend) begin
                            r_state     <= StSync;
                            r_sym_out   <= 2'd3;
                            r_sym_valid <= 1'b1;
                        end else begin
                            r_sym_out   <= IDLE_SYM;
                            r_sym_valid <= 1'b0;
                        end
                    end
                    StShift: begin
                        if (r_idx != 2'd3) begin
                            r_idx       <= r_idx + 1'b1;
                            r_shreg     <= {r_shreg[5:0], 2'b00};
                            r_sym_out   <= r_shreg[5:4];
                            r_sym_valid <= 1'b1;
                        end else if (r_pend) begin
                            r_state     <= StSync;
                            r_sym_out   <= 2'd3;
                            r_sym_valid <= 1'b1;
                        end else begin
                            r_state     <= StIdle;
                            r_sym_out   <= IDLE_SYM;
                            r_sym_valid <= 1'b0;
                        end
                    end
                    StSync: begin
                        if (i_sync_req) begin
                            r_state     <= StSync;
                            r_sym_out   <= 2'd3;
                            r_sym_valid <= 1'b1;
                        end else begin
                            r_state     <= StIdle;
                            r_sym_out   <= IDLE_SYM;
                            r_sym_valid <= 1'b0;
                        end
                    end
                    default: begin
                        r_state     <= StIdle;
                        r_sym_out   <= IDLE_SYM;
                        r_sym_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_full      = w_full;
    assign o_empty     = w_empty;
    assign o_overflow  = r_overflow;
    assign o_sym_out   = r_sym_out;
    assign o_sym_valid = r_sym_valid;

endmodule

// File: tb/tb_sym_feeder.sv
// Directed bench for sym_feeder: unpacking order, back-to-back bytes, sync insertion,
// overflow, mid-byte reset and repeated sync.
module tb_sym_feeder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'd0;
    logic       sync_req = 1'b0;
    logic       full;
    logic       empty;
    logic       overflow;
    logic [1:0] sym_out;
    logic       sym_valid;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sym_feeder #(
        .DEPTH    (4),
        .IDLE_SYM (2'd0)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_wr_en     (wr_en),
        .i_wr_data   (wr_data),
        .o_full      (full),
        .o_empty     (empty),
        .o_overflow  (overflow),
        .i_sync_req  (sync_req),
        .o_sym_out   (sym_out),
        .o_sym_valid (sym_valid)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) tick();
        n_cmp++;
        if ({sym_valid, sym_out, empty, full, overflow} !== 5'b0_00_1_0_0) begin
            n_err++;
            $display("FAIL reset_state: got %b expected %b",
                     {sym_valid, sym_out, empty, full, overflow}, 5'b0_00_1_0_0);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_byte;
        logic [1:0] exp [4];
        exp[0] = 2'd2; exp[1] = 2'd1; exp[2] = 2'd0; exp[3] = 2'd3;
        wr_en = 1'b1; wr_data = 8'h93;
        tick();
        wr_en = 1'b0;
        n_cmp++;
        if ({sym_valid, empty} !== 2'b00) begin
            n_err++;
            $display("FAIL single_after_write: got %b expected %b", {sym_valid, empty}, 2'b00);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++;
            if ({sym_valid, sym_out} !== {1'b1, exp[i]}) begin
                n_err++;
                $display("FAIL single_sym%0d: got %b expected %b", i, {sym_valid, sym_out},
                         {1'b1, exp[i]});
            end
        end
        tick();
        n_cmp++;
        if ({sym_valid, sym_out, empty} !== 4'b0_00_1) begin
            n_err++;
            $display("FAIL single_idle: got %b expected %b", {sym_valid, sym_out, empty}, 4'b0001);
        end
    endtask

    task automatic test_back_to_back;
        logic [1:0] exp [8];
        exp[0] = 2'd0; exp[1] = 2'd2; exp[2] = 2'd0; exp[3] = 2'd1;
        exp[4] = 2'd2; exp[5] = 2'd0; exp[6] = 2'd1; exp[7] = 2'd0;
        wr_en = 1'b1; wr_data = 8'h21;
        tick();
        wr_data = 8'h84;
        tick();
        wr_en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) tick();
            n_cmp++;
            if ({sym_valid, sym_out} !== {1'b1, exp[i]}) begin
                n_err++;
                $display("FAIL b2b_sym%0d: got %b expected %b", i, {sym_valid, sym_out},
                         {1'b1, exp[i]});
            end
        end
        tick();
        n_cmp++;
        if ({sym_valid, sym_out, empty} !== 4'b0_00_1) begin
            n_err++;
            $display("FAIL b2b_idle: got %b expected %b", {sym_valid, sym_out, empty}, 4'b0001);
        end
    endtask

    task automatic test_sync_insert;
        logic [1:0] exp [9];
        exp[0] = 2'd0; exp[1] = 2'd2; exp[2] = 2'd0; exp[3] = 2'd1; exp[4] = 2'd3;
        exp[5] = 2'd2; exp[6] = 2'd0; exp[7] = 2'd1; exp[8] = 2'd0;
        wr_en = 1'b1; wr_data = 8'h21;
        tick();
        wr_data = 8'h84;
        tick();
        wr_en = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (i > 0) tick();
            n_cmp++;
            if ({sym_valid, sym_out} !== {1'b1, exp[i]}) begin
                n_err++;
                $display("FAIL sync_sym%0d: got %b expected %b", i, {sym_valid, sym_out},
                         {1'b1, exp[i]});
            end
            sync_req = (i == 1);
        end
        sync_req = 1'b0;
        tick();
        n_cmp++;
        if ({sym_valid, sym_out, empty} !== 4'b0_00_1) begin
            n_err++;
            $display("FAIL sync_idle: got %b expected %b", {sym_valid, sym_out, empty}, 4'b0001);
        end
    endtask

    task automatic test_overflow;
        logic [7:0] b [6];
        logic [7:0] cur;
        int         sidx;
        b[0] = 8'h00; b[1] = 8'h55; b[2] = 8'hAA; b[3] = 8'h11; b[4] = 8'h22; b[5] = 8'h33;
        sidx = 0;
        for (int c = 0; c < 36; c++) begin
            if (c < 6) begin
                wr_en = 1'b1; wr_data = b[c];
            end else begin
                wr_en = 1'b0;
            end
            tick();
            if (c == 3) begin
                n_cmp++;
                if (full !== 1'b0) begin
                    n_err++;
                    $display("FAIL ovf_not_full_early: got %b expected 0", full);
                end
            end
            if (c == 4) begin
                n_cmp++;
                if ({full, overflow} !== 2'b10) begin
                    n_err++;
                    $display("FAIL ovf_full: got %b expected 10", {full, overflow});
                end
            end
            if (c == 5) begin
                n_cmp++;
                if (overflow !== 1'b1) begin
                    n_err++;
                    $display("FAIL ovf_set: got %b expected 1", overflow);
                end
            end
            if (sym_valid === 1'b1) begin
                if (sidx < 20) begin
                    cur = b[sidx / 4];
                    n_cmp++;
                    if (sym_out !== cur[7 - 2 * (sidx % 4) -: 2]) begin
                        n_err++;
                        $display("FAIL ovf_sym%0d: got %0d expected %0d", sidx, sym_out,
                                 cur[7 - 2 * (sidx % 4) -: 2]);
                    end
                end
                sidx++;
            end
        end
        n_cmp++;
        if (sidx != 20) begin
            n_err++;
            $display("FAIL ovf_sym_count: got %0d expected 20", sidx);
        end
        n_cmp++;
        if ({overflow, empty} !== 2'b11) begin
            n_err++;
            $display("FAIL ovf_sticky: got %b expected 11", {overflow, empty});
        end
    endtask

    task automatic test_reset_mid_byte;
        int         quiet;
        logic [1:0] exp [4];
        exp[0] = 2'd0; exp[1] = 2'd1; exp[2] = 2'd2; exp[3] = 2'd3;
        wr_en = 1'b1; wr_data = 8'hE4;
        tick();
        wr_data = 8'hFF;
        tick();
        wr_en = 1'b0;
        tick();
        tick();
        n_cmp++;
        if ({sym_valid, sym_out} !== 3'b1_01) begin
            n_err++;
            $display("FAIL rst_pre_sym: got %b expected %b", {sym_valid, sym_out}, 3'b101);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({sym_valid, sym_out, empty, full, overflow} !== 5'b0_00_1_0_0) begin
            n_err++;
            $display("FAIL rst_async: got %b expected %b",
                     {sym_valid, sym_out, empty, full, overflow}, 5'b0_00_1_0_0);
        end
        tick();
        tick();
        rst_n = 1'b1;
        quiet = 0;
        repeat (8) begin
            tick();
            if (sym_valid !== 1'b0) quiet++;
        end
        n_cmp++;
        if ({quiet[3:0], empty} !== 5'b0000_1) begin
            n_err++;
            $display("FAIL rst_quiet: got valid_cycles=%0d empty=%b expected 0 and 1", quiet,
                     empty);
        end
        wr_en = 1'b1; wr_data = 8'h1B;
        tick();
        wr_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++;
            if ({sym_valid, sym_out} !== {1'b1, exp[i]}) begin
                n_err++;
                $display("FAIL rst_after_sym%0d: got %b expected %b", i, {sym_valid, sym_out},
                         {1'b1, exp[i]});
            end
        end
        tick();
    endtask

    task automatic test_double_sync;
        sync_req = 1'b1;
        tick();
        sync_req = 1'b0;
        n_cmp++;
        if (sym_valid !== 1'b0) begin
            n_err++;
            $display("FAIL dsync_pending: got valid %b expected 0", sym_valid);
        end
        tick();
        n_cmp++;
        if ({sym_valid, sym_out} !== 3'b1_11) begin
            n_err++;
            $display("FAIL dsync_first: got %b expected %b", {sym_valid, sym_out}, 3'b111);
        end
        sync_req = 1'b1;
        tick();
        sync_req = 1'b0;
        n_cmp++;
        if ({sym_valid, sym_out} !== 3'b1_11) begin
            n_err++;
            $display("FAIL dsync_second: got %b expected %b", {sym_valid, sym_out}, 3'b111);
        end
        tick();
        n_cmp++;
        if ({sym_valid, sym_out} !== 3'b0_00) begin
            n_err++;
            $display("FAIL dsync_idle: got %b expected %b", {sym_valid, sym_out}, 3'b000);
        end
        tick();
        n_cmp++;
        if ({sym_valid, sym_out, empty} !== 4'b0_00_1) begin
            n_err++;
            $display("FAIL dsync_idle2: got %b expected %b", {sym_valid, sym_out, empty},
                     4'b0001);
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_sync_insert();
        test_overflow();
        test_reset_mid_byte();
        test_double_sync();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sym_feeder.md
Name: sym_feeder

Overview:
- Upstream stimulus stage for the 2-bit symbol-stream FSM (in[1:0] consumed every clk; symbol 3 = reset command).
- Accepts packed bytes from a producer into a small FIFO and unpacks each byte into four 2-bit symbols, MSB pair first, one per cycle.
- Inserts a sync symbol (3) on request at byte boundaries.
- Drives IDLE_SYM when there is nothing to send, because the consumer has no valid input.

Parameters:
- DEPTH, 4, FIFO depth in bytes; power of 2, at least 2.
- IDLE_SYM, 2'd0, symbol driven when idle; must not be 3.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- wr_en  input  1  byte write request
- wr_data  input  8  byte to queue; symbols [7:6],[5:4],[3:2],[1:0]
- full  output  1  FIFO count == DEPTH (from registered count)
- empty  output  1  FIFO count == 0
- overflow  output  1  sticky; set when a write is rejected
- sync_req  input  1  one-cycle pulse requesting a symbol-3 emission
- sym_out  output  2  symbol to downstream FSM input
- sym_valid  output  1  1 when sym_out carries a data or sync symbol

Behaviour:
- Reset (async, rst_n=0), immediate and held while low:
  - FIFO pointers and count = 0; empty=1, full=0, overflow=0.
  - sync pending flag = 0; state = IDLE.
  - sym_out = IDLE_SYM, sym_valid = 0.
  - Reset mid-byte discards the partial byte and all queued bytes.
- FIFO writes:
  - A write is accepted on an edge when wr_en=1 and full=0.
  - wr_en=1 with full=1 drops the byte and sets overflow. This holds even if a pop occurs on the same edge, because full is the registered value.
  - A simultaneous accepted push and a pop leave the count unchanged.
  - Count width is clog2(DEPTH)+1.
- States: IDLE, SHIFT (2-bit index 0..3), SYNC.
- IDLE:
  - Outputs: sym_out=IDLE_SYM, sym_valid=0.
  - If pend=1 → SYNC. Sync has priority over data.
  - Else if empty=0 → pop the head byte into the shift register; → SHIFT with idx=0.
- SHIFT:
  - Outputs: sym_out=shreg[7-2*idx -: 2], sym_valid=1.
  - idx<3: idx+1.
  - idx==3 and pend=1 → SYNC.
  - idx==3, pend=0, empty=0 → pop the next byte and reload with idx=0, with no bubble.
  - idx==3, otherwise → IDLE.
- SYNC:
  - Outputs: sym_out=3, sym_valid=1, for exactly one cycle.
  - Clears pend, unless sync_req=1 in this cycle, in which case pend stays 1.
  - Next state: SYNC again if pend=1 stays set; else SHIFT (pop) if the FIFO is non-empty; else IDLE.
- sync_req handling:
  - The pend flag is set on any edge with sync_req=1.
  - Multiple requests before emission merge into one 3.
  - A sync is never emitted mid-byte.
- Latency:
  - A byte written on edge k into an empty FIFO with state IDLE is popped on edge k+1.
  - Its first symbol is visible after edge k+1.
  - Its four symbols occupy the cycles after edges k+1..k+4.
- sym_out and sym_valid are driven from registered state only, with no combinational path from the inputs.

Test Plan:
1. Idle, DEPTH=4; write 0x93 once → sym_out 2,1,0,3 with valid=1 for 4 consecutive cycles starting after the following edge; then sym_out=0 with valid=0; empty back to 1.
2. Write 0x21 then 0x84 on consecutive edges → 8 gapless valid symbols 0,2,0,1,2,0,1,0, then idle.
3. Repeat 2, pulsing sync_req during the 2nd symbol of 0x21 → 0,2,0,1,3,2,0,1,0, with exactly one 3.
4. Write 6 bytes (0x00,0x55,0xAA,0x11,0x22,0x33) on consecutive edges k..k+5 → full=1 after edge k+4; the 6th byte is rejected at edge k+5 despite the simultaneous pop; overflow=1 and stays 1; exactly 20 data symbols out (5 bytes).
5. Drop rst_n low during the 3rd symbol of 0xE4 with 0xFF queued → immediately sym_valid=0, sym_out=0, empty=1, overflow=0; after release nothing is emitted until a new write.
6. Idle and empty; pulse sync_req, then pulse again in the cycle sym_out=3 → two consecutive cycles of sym_out=3 with valid=1, then idle.
